// File: rtl/com_cdc_toggle_evt_rx.sv
// Purpose: multi-channel toggle-event receiver. Synchronises async toggle lines into clk,
//          turns each level change into a one-cycle pulse and per-channel pending count.
//          Pending events are offered as a round-robin arbitrated valid/ready stream.
// Latency: toggle capture edge 0 -> opulse/pending at edge SYNC_STAGES -> oevt_vld at edge SYNC_STAGES+1.
// Backpressure: oevt_vld/oevt_ch held until ievt_rdy; events queue in saturating counters (oovf on loss).
// Ports: clk, rst_n (async active-low); itoggle[CH_N] async toggles; opulse[CH_N] event pulses;
//        oevt_vld/oevt_ch/ievt_rdy event stream; opend packed pending counts; oovf/iovf_clr sticky overflow.
module com_cdc_toggle_evt_rx #(
    parameter int  CH_N        = 4,
    parameter int  SYNC_STAGES = 2,
    parameter int  CNT_W       = 4,
    localparam int CH_IDX_W    = (CH_N > 1) ? $clog2(CH_N) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CH_N-1:0]       itoggle,
    output logic [CH_N-1:0]       opulse,
    output logic                  oevt_vld,
    output logic [CH_IDX_W-1:0]   oevt_ch,
    input  logic                  ievt_rdy,
    output logic [CH_N*CNT_W-1:0] opend,
    output logic [CH_N-1:0]       oovf,
    input  logic [CH_N-1:0]       iovf_clr
);

    typedef enum logic {IDLE, OFFER} state_t;

    logic [SYNC_STAGES-1:0] sync_q [CH_N];
    logic [CH_N-1:0]        hist_q;
    logic [CH_N-1:0]        det;
    logic [CNT_W-1:0]       cnt_q [CH_N];
    logic [CH_N-1:0]        dec;
    logic [CH_N-1:0]        sat_hit;
    logic [CH_N-1:0]        pend_nz;
    logic                   accept;
    state_t                 state;
    logic [CH_IDX_W-1:0]    rr_q;
    logic                   sel_vld;
    logic [CH_IDX_W-1:0]    sel_ch;
    int                     best_off;
    int                     off;

    assign accept = oevt_vld & ievt_rdy;

    // Edge detect on the synchronised level; inc/dec in the same cycle cancel out.
    always_comb begin
        det     = '0;
        dec     = '0;
        sat_hit = '0;
        pend_nz = '0;
        for (int c = 0; c < CH_N; c++) begin
            det[c]     = sync_q[c][SYNC_STAGES-1] ^ hist_q[c];
            dec[c]     = accept && (oevt_ch == CH_IDX_W'(c));
            sat_hit[c] = det[c] && !dec[c] && (cnt_q[c] == '1);
            pend_nz[c] = (cnt_q[c] != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < CH_N; c++) begin
                sync_q[c] <= '0;
                cnt_q[c]  <= '0;
            end
            hist_q <= '0;
            opulse <= '0;
            oovf   <= '0;
        end else begin
            for (int c = 0; c < CH_N; c++) begin
                sync_q[c] <= {sync_q[c][SYNC_STAGES-2:0], itoggle[c]};
                hist_q[c] <= sync_q[c][SYNC_STAGES-1];
                opulse[c] <= det[c];
                if (det[c] && !dec[c] && !sat_hit[c])
                    cnt_q[c] <= cnt_q[c] + CNT_W'(1);
                else if (dec[c] && !det[c])
                    cnt_q[c] <= cnt_q[c] - CNT_W'(1);
                // A lost event in the same cycle as a clear keeps the flag set.
                if (sat_hit[c])
                    oovf[c] <= 1'b1;
                else if (iovf_clr[c])
                    oovf[c] <= 1'b0;
            end
        end
    end

    // Round-robin pick: smallest wrapped distance from the pointer among non-zero counters.
    always_comb begin
        sel_vld  = 1'b0;
        sel_ch   = '0;
        best_off = CH_N;
        off      = 0;
        for (int c = 0; c < CH_N; c++) begin
            off = c - int'(rr_q);
            if (off < 0)
                off = off + CH_N;
            if (pend_nz[c] && (off < best_off)) begin
                best_off = off;
                sel_vld  = 1'b1;
                sel_ch   = CH_IDX_W'(c);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            oevt_vld <= 1'b0;
            oevt_ch  <= '0;
            rr_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_vld) begin
                        oevt_ch  <= sel_ch;
                        oevt_vld <= 1'b1;
                        state    <= OFFER;
                    end
                end
                OFFER: begin
                    if (ievt_rdy) begin
                        oevt_vld <= 1'b0;
                        rr_q     <= (oevt_ch == CH_IDX_W'(CH_N-1)) ? '0 : oevt_ch + CH_IDX_W'(1);
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < CH_N; g++) begin : g_pend
        assign opend[g*CNT_W +: CNT_W] = cnt_q[g];
    end

endmodule

// File: tb/tb_com_cdc_toggle_evt_rx.sv
module tb_com_cdc_toggle_evt_rx;
    localparam int CH_N = 4;
    localparam int SS   = 2;
    localparam int CNT_W = 4;
    localparam int IW   = 2;
    localparam int CMAX = (1 << CNT_W) - 1;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic [CH_N-1:0]       itoggle = '0;
    logic [CH_N-1:0]       opulse;
    logic                  oevt_vld;
    logic [IW-1:0]         oevt_ch;
    logic                  ievt_rdy = 1'b0;
    logic [CH_N*CNT_W-1:0] opend;
    logic [CH_N-1:0]       oovf;
    logic [CH_N-1:0]       iovf_clr = '0;

    com_cdc_toggle_evt_rx #(.CH_N(CH_N), .SYNC_STAGES(SS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .itoggle(itoggle), .opulse(opulse),
        .oevt_vld(oevt_vld), .oevt_ch(oevt_ch), .ievt_rdy(ievt_rdy),
        .opend(opend), .oovf(oovf), .iovf_clr(iovf_clr)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: pending counts, RR pointer, currently offered channel, expected grant queue.
    int              m_cnt[CH_N];
    int              m_ptr = 0;
    int              m_off = -1;
    bit [CH_N-1:0]   m_ovf = '0;
    int              exp_q[$];
    int              exp_pulse[CH_N];
    int              got_pulse[CH_N];

    function automatic int pick();
        for (int i = 0; i < CH_N; i++)
            if (m_cnt[(m_ptr + i) % CH_N] > 0) return (m_ptr + i) % CH_N;
        return -1;
    endfunction

    function automatic void model_arrive(input bit [CH_N-1:0] mask, input bit [CH_N-1:0] clr);
        bit [CH_N-1:0] lost = '0;
        for (int c = 0; c < CH_N; c++) begin
            if (mask[c]) begin
                exp_pulse[c]++;
                if (m_cnt[c] == CMAX) lost[c] = 1'b1;
                else m_cnt[c]++;
            end
        end
        m_ovf = (m_ovf & ~clr) | lost;
        if (m_off < 0) begin
            m_off = pick();
            if (m_off >= 0) exp_q.push_back(m_off);
        end
    endfunction

    function automatic void accept_one();
        m_cnt[m_off]--;
        m_ptr = (m_off + 1) % CH_N;
        m_off = pick();
        if (m_off >= 0) exp_q.push_back(m_off);
    endfunction

    // Monitor: grants popped against the scoreboard, offer stability, pulse counting.
    bit           prev_hold = 1'b0;
    logic [IW-1:0] prev_ch  = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hold = 1'b0;
        end else begin
            for (int c = 0; c < CH_N; c++)
                if (opulse[c]) got_pulse[c]++;
            if (prev_hold) begin
                check("offer_held_vld", oevt_vld, 1);
                check("offer_held_ch", oevt_ch, prev_ch);
            end
            if (oevt_vld && ievt_rdy) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    $display("FAIL grant_unexpected: got ch %0d expected no grant at %0t", oevt_ch, $time);
                end else begin
                    int e;
                    e = exp_q.pop_front();
                    n_chk--;
                    check("grant_ch", oevt_ch, e);
                end
            end
            prev_hold = oevt_vld && !ievt_rdy;
            prev_ch   = oevt_ch;
        end
    end

    task automatic check_state(input string tag);
        for (int c = 0; c < CH_N; c++) begin
            check($sformatf("%s_opend%0d", tag, c), opend[c*CNT_W +: CNT_W], m_cnt[c]);
            check($sformatf("%s_pulses%0d", tag, c), got_pulse[c], exp_pulse[c]);
        end
        check({tag, "_oovf"}, oovf, m_ovf);
    endtask

    // Toggle a set of channels and wait until the events are counted and offered.
    task automatic arrive(input bit [CH_N-1:0] mask, input bit [CH_N-1:0] clr);
        itoggle = itoggle ^ mask;
        model_arrive(mask, clr);
        @(posedge clk);
        @(posedge clk); #1 iovf_clr = clr;
        @(posedge clk); #1 iovf_clr = '0;
        @(posedge clk); #1;
    endtask

    task automatic run_drain(input bit rnd);
        while (m_off >= 0) accept_one();
        for (int k = 0; k < 3000; k++) begin
            ievt_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            if (exp_q.size() == 0 && !oevt_vld) break;
        end
        ievt_rdy = 1'b0;
        check("drain_done", (exp_q.size() == 0) && !oevt_vld, 1);
        check_state("drain");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int c = 0; c < CH_N; c++) begin
            m_cnt[c] = 0; exp_pulse[c] = 0; got_pulse[c] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_vld", oevt_vld, 0);
        check("rst_ch", oevt_ch, 0);
        check("rst_opend", opend, 0);
        check("rst_oovf", oovf, 0);
        check("rst_opulse", opulse, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Round robin: 0,1,3 together, then 3 and 0 with pointer back at 0.
        arrive(4'b1011, '0);
        check("rr_first_vld", oevt_vld, 1);
        check("rr_first_ch", oevt_ch, 0);
        run_drain(1'b0);
        arrive(4'b1001, '0);
        check("rr2_first_ch", oevt_ch, 0);
        run_drain(1'b0);

        // Single event latency on channel 2.
        itoggle[2] = ~itoggle[2];
        model_arrive(4'b0100, '0);
        @(posedge clk);
        @(posedge clk); #1;
        check("lat_pulse_early", opulse, 0);
        @(posedge clk); #1;
        check("lat_pulse", opulse, 4'b0100);
        check("lat_opend2", opend[2*CNT_W +: CNT_W], 1);
        check("lat_vld_early", oevt_vld, 0);
        @(posedge clk); #1;
        check("lat_vld", oevt_vld, 1);
        check("lat_ch", oevt_ch, 2);
        ievt_rdy = 1'b1;
        @(posedge clk); #1;
        ievt_rdy = 1'b0;
        accept_one();
        check("lat_acc_vld", oevt_vld, 0);
        check("lat_acc_opend", opend, 0);

        // Back-pressure: ch1 offered while ch0 accumulates.
        arrive(4'b0010, '0);
        repeat (5) arrive(4'b0001, '0);
        check("bp_ch", oevt_ch, 1);
        check("bp_vld", oevt_vld, 1);
        check_state("bp");
        run_drain(1'b1);

        // Saturation, clear, and set-beats-clear.
        repeat (17) arrive(4'b0001, '0);
        check_state("sat");
        iovf_clr = 4'b0001;
        @(posedge clk); #1 iovf_clr = '0;
        m_ovf[0] = 1'b0;
        check("sat_clr", oovf[0], 0);
        arrive(4'b0001, 4'b0001);
        check("sat_setclr", oovf[0], 1);
        run_drain(1'b1);
        iovf_clr = '1;
        @(posedge clk); #1 iovf_clr = '0;
        m_ovf = '0;

        // Increment and accept in the same cycle on channel 1.
        repeat (3) arrive(4'b0010, '0);
        check_state("simul_pre");
        itoggle[1] = ~itoggle[1];
        model_arrive(4'b0010, '0);
        accept_one();
        @(posedge clk);
        @(posedge clk); #1 ievt_rdy = 1'b1;
        @(posedge clk); #1 ievt_rdy = 1'b0;
        check("simul_opend1", opend[1*CNT_W +: CNT_W], 3);
        check("simul_pulse1", opulse[1], 1);
        @(posedge clk); #1;
        run_drain(1'b1);

        // Randomised bursts with optional overflow clears, drained with random ready.
        for (int p = 0; p < 25; p++) begin
            int nb;
            nb = $urandom_range(1, 20);
            for (int b = 0; b < nb; b++) begin
                bit [CH_N-1:0] m, cl;
                m  = CH_N'($urandom_range(1, (1 << CH_N) - 1));
                cl = ($urandom_range(0, 3) == 0) ? CH_N'($urandom_range(0, (1 << CH_N) - 1)) : '0;
                arrive(m, cl);
            end
            check_state("rnd");
            run_drain(1'b1);
        end

        // Async reset while offering with pending [2,0,5,1].
        iovf_clr = '1;
        @(posedge clk); #1 iovf_clr = '0;
        m_ovf = '0;
        arrive(4'b0101, '0);
        arrive(4'b1101, '0);
        repeat (3) arrive(4'b0100, '0);
        check_state("prerst");
        check("prerst_vld", oevt_vld, 1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        itoggle = '0;
        #1;
        check("arst_vld", oevt_vld, 0);
        check("arst_ch", oevt_ch, 0);
        check("arst_opend", opend, 0);
        check("arst_oovf", oovf, 0);
        check("arst_opulse", opulse, 0);
        for (int c = 0; c < CH_N; c++) m_cnt[c] = 0;
        m_ptr = 0; m_off = -1; m_ovf = '0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("postrst_vld", oevt_vld, 0);
        check_state("postrst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
